// File: rtl/y_zigzag_rle.sv
`default_nettype none
// ============================================================================
// Module   : y_zigzag_rle
// Purpose  : Serialises one quantized 8x8 luminance block into a JPEG symbol
//            stream: zig-zag reorder, DC DPCM, AC run-length coding (ZRL/EOB).
// Ports    : clk, rst (async, active-low)
//            enable / Q[8][8] / dc_clear : block capture and DC predictor ctl
//            busy, err_drop              : status (err_drop is sticky)
//            sym_valid / sym_ready       : output handshake
//            sym_is_dc, sym_run, sym_size, sym_amp, sym_last : symbol fields
// Revision : 1.0  initial release
// ============================================================================
module y_zigzag_rle #(
    parameter int DATA_W = 11,
    parameter int AMP_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] Q [0:7][0:7],
    input  logic                     dc_clear,
    output logic                     busy,
    output logic                     err_drop,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic                     sym_is_dc,
    output logic [3:0]               sym_run,
    output logic [3:0]               sym_size,
    output logic [AMP_W-1:0]         sym_amp,
    output logic                     sym_last
);

    // Zig-zag scan order k -> row-major index (row = idx[5:3], col = idx[2:0])
    localparam logic [5:0] ZZ [0:63] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // S_LAST holds the final symbol of the block (EOB or coefficient 63)
    typedef enum logic [1:0] {S_IDLE, S_DC, S_SCAN, S_LAST} state_t;

    // Bit length of |v|; 0 for v == 0
    function automatic logic [3:0] mag_size(input logic signed [AMP_W-1:0] v);
        logic [AMP_W-1:0] mag;
        mag      = v[AMP_W-1] ? $unsigned(-v) : $unsigned(v);
        mag_size = 4'd0;
        for (int i = 0; i < AMP_W; i++)
            if (mag[i]) mag_size = 4'(i + 1);
    endfunction

    // JPEG amplitude bits: negative values are sent as (v-1) truncated to size bits
    function automatic logic [AMP_W-1:0] amp_bits(input logic signed [AMP_W-1:0] v,
                                                  input logic [3:0] size);
        logic [AMP_W-1:0] raw;
        logic [AMP_W-1:0] mask;
        mask     = ~({AMP_W{1'b1}} << size);
        raw      = v[AMP_W-1] ? ($unsigned(v) + {AMP_W{1'b1}}) : $unsigned(v);
        amp_bits = raw & mask;
    endfunction

    state_t                    state, state_nx;
    logic [5:0]                k, k_nx;
    logic [5:0]                run, run_nx;
    logic signed [DATA_W-1:0]  pred, pred_nx;
    logic                      busy_nx, err_nx;
    logic                      valid_nx, is_dc_nx, last_nx;
    logic [3:0]                srun_nx, size_nx;
    logic [AMP_W-1:0]          amp_nx;
    logic signed [DATA_W-1:0]  coef [0:63];

    logic                      accept, capture;
    logic signed [AMP_W-1:0]   q00_ext, pred_ext, diff, cur_ext;
    logic [3:0]                diff_size, cur_size;

    // Coefficient store, written in zig-zag order on capture
    for (genvar i = 0; i < 64; i++) begin : g_zz
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)         coef[i] <= '0;
            else if (capture) coef[i] <= Q[ZZ[i][5:3]][ZZ[i][2:0]];
        end
    end

    assign q00_ext   = {{(AMP_W-DATA_W){Q[0][0][DATA_W-1]}}, Q[0][0]};
    assign pred_ext  = dc_clear ? '0 : {{(AMP_W-DATA_W){pred[DATA_W-1]}}, pred};
    assign diff      = q00_ext - pred_ext;
    assign diff_size = mag_size(diff);
    assign cur_ext   = {{(AMP_W-DATA_W){coef[k][DATA_W-1]}}, coef[k]};
    assign cur_size  = mag_size(cur_ext);
    assign accept    = sym_valid && sym_ready;
    // A new block may be taken in IDLE or on the edge retiring the last symbol
    assign capture   = enable && ((state == S_IDLE) || (accept && sym_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            run       <= '0;
            pred      <= '0;
            busy      <= 1'b0;
            err_drop  <= 1'b0;
            sym_valid <= 1'b0;
            sym_is_dc <= 1'b0;
            sym_run   <= '0;
            sym_size  <= '0;
            sym_amp   <= '0;
            sym_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            k         <= k_nx;
            run       <= run_nx;
            pred      <= pred_nx;
            busy      <= busy_nx;
            err_drop  <= err_nx;
            sym_valid <= valid_nx;
            sym_is_dc <= is_dc_nx;
            sym_run   <= srun_nx;
            sym_size  <= size_nx;
            sym_amp   <= amp_nx;
            sym_last  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        run_nx   = run;
        pred_nx  = pred;
        busy_nx  = busy;
        err_nx   = err_drop;
        valid_nx = sym_valid;
        is_dc_nx = sym_is_dc;
        srun_nx  = sym_run;
        size_nx  = sym_size;
        amp_nx   = sym_amp;
        last_nx  = sym_last;

        if (dc_clear)           pred_nx = '0;
        if (enable && !capture) err_nx  = 1'b1;

        case (state)
            S_DC: begin
                if (accept) begin
                    valid_nx = 1'b0;
                    state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!sym_valid || sym_ready) begin
                    valid_nx = 1'b0;
                    if (coef[k] == '0) begin
                        run_nx = run + 6'd1;
                        if (k == 6'd63) begin
                            // Trailing zeros collapse into a single EOB
                            valid_nx = 1'b1;
                            is_dc_nx = 1'b0;
                            srun_nx  = 4'd0;
                            size_nx  = 4'd0;
                            amp_nx   = '0;
                            last_nx  = 1'b1;
                            state_nx = S_LAST;
                        end else begin
                            k_nx = k + 6'd1;
                        end
                    end else if (run > 6'd15) begin
                        // ZRL: 16 zeros; k holds so the coefficient is re-examined
                        valid_nx = 1'b1;
                        is_dc_nx = 1'b0;
                        srun_nx  = 4'd15;
                        size_nx  = 4'd0;
                        amp_nx   = '0;
                        last_nx  = 1'b0;
                        run_nx   = run - 6'd16;
                    end else begin
                        valid_nx = 1'b1;
                        is_dc_nx = 1'b0;
                        srun_nx  = run[3:0];
                        size_nx  = cur_size;
                        amp_nx   = amp_bits(cur_ext, cur_size);
                        last_nx  = (k == 6'd63);
                        run_nx   = '0;
                        if (k == 6'd63) state_nx = S_LAST;
                        else            k_nx     = k + 6'd1;
                    end
                end
            end
            S_LAST: begin
                if (accept) begin
                    valid_nx = 1'b0;
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: ;
        endcase

        // Capture overrides the retire path so back-to-back blocks keep busy high
        if (capture) begin
            pred_nx  = Q[0][0];
            busy_nx  = 1'b1;
            state_nx = S_DC;
            k_nx     = 6'd1;
            run_nx   = '0;
            valid_nx = 1'b1;
            is_dc_nx = 1'b1;
            srun_nx  = 4'd0;
            size_nx  = diff_size;
            amp_nx   = amp_bits(diff, diff_size);
            last_nx  = 1'b0;
        end
    end

endmodule
`default_nettype wire
